// File: rtl/ps2_kb_pkg.sv
// Shared PS/2 Set-2 definitions: scan-code constants, prefix FSM states and
// the scan-code to ASCII lookup used by the decoder.
package ps2_kb_pkg;

  localparam logic [7:0] SC_E0       = 8'hE0;
  localparam logic [7:0] SC_F0       = 8'hF0;
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CAPS     = 8'h58;
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_KP_ENTER = 8'h5A;
  localparam logic [7:0] SC_KP_SLASH = 8'h4A;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } prefix_state_t;

  // Non-extended make codes only; 8'h00 means "no character".
  // 'shifted' selects uppercase for letters and the symbol row for digits.
  function automatic logic [7:0] ascii_lut(input logic [7:0] code, input logic shifted);
    logic [7:0] ch;
    ch = 8'h00;
    case (code)
      8'h1C: ch = "a";
      8'h32: ch = "b";
      8'h21: ch = "c";
      8'h23: ch = "d";
      8'h24: ch = "e";
      8'h2B: ch = "f";
      8'h34: ch = "g";
      8'h33: ch = "h";
      8'h43: ch = "i";
      8'h3B: ch = "j";
      8'h42: ch = "k";
      8'h4B: ch = "l";
      8'h3A: ch = "m";
      8'h31: ch = "n";
      8'h44: ch = "o";
      8'h4D: ch = "p";
      8'h15: ch = "q";
      8'h2D: ch = "r";
      8'h1B: ch = "s";
      8'h2C: ch = "t";
      8'h3C: ch = "u";
      8'h2A: ch = "v";
      8'h1D: ch = "w";
      8'h22: ch = "x";
      8'h35: ch = "y";
      8'h1A: ch = "z";
      8'h45: ch = shifted ? ")" : "0";
      8'h16: ch = shifted ? "!" : "1";
      8'h1E: ch = shifted ? "@" : "2";
      8'h26: ch = shifted ? "#" : "3";
      8'h25: ch = shifted ? "$" : "4";
      8'h2E: ch = shifted ? "%" : "5";
      8'h36: ch = shifted ? "^" : "6";
      8'h3D: ch = shifted ? "&" : "7";
      8'h3E: ch = shifted ? "*" : "8";
      8'h46: ch = shifted ? "(" : "9";
      8'h29: ch = 8'h20;
      SC_ENTER: ch = 8'h0D;
      8'h66: ch = 8'h08;
      8'h0D: ch = 8'h09;
      8'h76: ch = 8'h1B;
      default: ch = 8'h00;
    endcase
    if (shifted && ch >= "a" && ch <= "z") ch = ch - 8'h20;
    return ch;
  endfunction

  function automatic logic is_letter(input logic [7:0] code);
    logic [7:0] lc;
    lc = ascii_lut(code, 1'b0);
    return (lc >= "a") && (lc <= "z");
  endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word fall-through FIFO; head reads 0 when empty. A pop on an empty
// FIFO is ignored, and a push while full only lands alongside a pop.
module key_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_MAX);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointers are exactly AW bits wide, so wrap is free for power-of-two depths.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan codes to buffered ASCII: E0/F0 prefix tracking, Shift and
// Caps Lock state, and a FWFT character FIFO with sticky overflow.
module ps2_scancode_decoder
  import ps2_kb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        sys_clk,
  input  logic                        reset_n,
  input  logic [7:0]                  code_i,
  input  logic                        code_valid_i,
  output logic [7:0]                  key_ascii_o,
  output logic                        key_valid_o,
  input  logic                        key_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        overflow_o,
  output logic                        shift_o,
  output logic                        caps_o
);

  prefix_state_t state, state_nx;
  logic          lshift, rshift, caps;
  logic          lshift_nx, rshift_nx, caps_nx;
  logic          push_nx, push_q;
  logic [7:0]    char_nx, char_q, mapped;
  logic          shift_q, caps_q, ovf_q;
  logic          fifo_full, fifo_empty, pop;

  // Lookup uses modifier state from before this code, never its own update.
  always_comb begin
    mapped = ascii_lut(code_i, is_letter(code_i) ? ((lshift | rshift) ^ caps)
                                                 : (lshift | rshift));
  end

  always_comb begin
    state_nx  = state;
    lshift_nx = lshift;
    rshift_nx = rshift;
    caps_nx   = caps;
    push_nx   = 1'b0;
    char_nx   = 8'h00;
    if (code_valid_i) begin
      case (state)
        ST_IDLE: begin
          if (code_i == SC_E0)          state_nx  = ST_GOT_E0;
          else if (code_i == SC_F0)     state_nx  = ST_GOT_F0;
          else if (code_i == SC_LSHIFT) lshift_nx = 1'b1;
          else if (code_i == SC_RSHIFT) rshift_nx = 1'b1;
          else if (code_i == SC_CAPS)   caps_nx   = ~caps;
          else if (mapped != 8'h00) begin
            push_nx = 1'b1;
            char_nx = mapped;
          end
        end
        ST_GOT_E0: begin
          // E0 12 / E0 59 are fake shifts and fall through as dropped makes.
          state_nx = ST_IDLE;
          if (code_i == SC_F0) state_nx = ST_GOT_E0F0;
          else if (code_i == SC_KP_ENTER) begin
            push_nx = 1'b1;
            char_nx = 8'h0D;
          end else if (code_i == SC_KP_SLASH) begin
            push_nx = 1'b1;
            char_nx = 8'h2F;
          end
        end
        ST_GOT_F0: begin
          state_nx = ST_IDLE;
          if (code_i == SC_LSHIFT)      lshift_nx = 1'b0;
          else if (code_i == SC_RSHIFT) rshift_nx = 1'b0;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      lshift  <= 1'b0;
      rshift  <= 1'b0;
      caps    <= 1'b0;
      push_q  <= 1'b0;
      char_q  <= 8'h00;
      shift_q <= 1'b0;
      caps_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      lshift  <= lshift_nx;
      rshift  <= rshift_nx;
      caps    <= caps_nx;
      push_q  <= push_nx;
      char_q  <= char_nx;
      // Modifier outputs trail the internal state by one edge to line up
      // with the character pipeline.
      shift_q <= lshift | rshift;
      caps_q  <= caps;
      if (push_q && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  assign pop = key_valid_o && key_ready_i;

  key_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .push    (push_q),
    .wdata   (char_q),
    .pop     (pop),
    .rdata   (key_ascii_o),
    .level   (level_o),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign key_valid_o = !fifo_empty;
  assign overflow_o  = ovf_q;
  assign shift_o     = shift_q;
  assign caps_o      = caps_q;

endmodule
